// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared types and default sizing for the block-RAM burst controller.
//   burst_state_t : controller FSM states
//   DEF_*         : default RAM geometry and burst limit
//   ADDR_W/LEN_W  : address and length widths derived from the defaults
// ---------------------------------------------------------------------------
package bram_pkg;

    localparam int unsigned DEF_ADDRESS_DEPTH = 4092;
    localparam int unsigned DEF_DATA_WIDTH    = 16;
    localparam int unsigned DEF_MAX_BURST     = 256;

    localparam int unsigned ADDR_W = $clog2(DEF_ADDRESS_DEPTH);
    localparam int unsigned LEN_W  = $clog2(DEF_MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } burst_state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// ---------------------------------------------------------------------------
// rd_skid_buf
// Two-entry in-order buffer holding RAM read data until the sink takes it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the buffer)
//   push       : capture push_data this edge
//   push_data  : word to capture
//   pop        : head word consumed this edge
//   head_data  : oldest stored word
//   count      : number of stored words (0..2), used for read-issue gating
//   empty      : no word stored
// A push while full is only taken if a pop happens on the same edge.
// ---------------------------------------------------------------------------
module rd_skid_buf #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;
    logic                  do_pop;
    logic                  do_push;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/bram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// bram_burst_ctrl
// Turns burst commands (start address, length, direction) into per-cycle
// accesses on one single-port block RAM with a one-cycle read latency.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len  : direction, start word, word count
//   wr_data/wr_valid/wr_ready     : write data stream into the RAM
//   rd_data/rd_valid/rd_ready     : read data stream out of the RAM
//   done                          : one-cycle pulse when a command completes
//   err                           : with done, command had an illegal address
//   mem_wr, mem_data, mem_address : RAM write enable, write data, address
//   mem_q                         : RAM read data, cycle after the address
// Addresses wrap from ADDRESS_DEPTH-1 to 0 inside a burst.
// ---------------------------------------------------------------------------
module bram_burst_ctrl
    import bram_pkg::*;
#(
    parameter int unsigned ADDRESS_DEPTH = DEF_ADDRESS_DEPTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned MAX_BURST     = DEF_MAX_BURST
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [$clog2(ADDRESS_DEPTH)-1:0] cmd_addr,
    input  logic [$clog2(MAX_BURST+1)-1:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic                             done,
    output logic                             err,
    output logic                             mem_wr,
    output logic [DATA_WIDTH-1:0]            mem_data,
    output logic [$clog2(ADDRESS_DEPTH)-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0]            mem_q
);

    localparam int unsigned AW  = $clog2(ADDRESS_DEPTH);
    localparam int unsigned LW  = $clog2(MAX_BURST + 1);
    localparam int unsigned AW1 = AW + 1;

    // One extra bit so a power-of-two depth still compares correctly.
    localparam logic [AW:0]   DEPTH_EXT = AW1'(ADDRESS_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ADDRESS_DEPTH - 1);

    burst_state_t  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] issue_left_q, issue_left_d;  // words still to write / to issue
    logic [LW-1:0] out_left_q, out_left_d;      // read words still to hand off
    logic          inflight_q, inflight_d;      // read issued last cycle
    logic          err_q, err_d;

    logic [AW-1:0] addr_next;
    logic          addr_bad;
    logic [1:0]    buf_count;
    logic [1:0]    occupancy;
    logic          buf_empty;
    logic          pop;
    logic          issue;

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mem_q),
        .pop       (pop),
        .head_data (rd_data),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    always_comb begin
        addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
        addr_bad  = ({1'b0, cmd_addr} >= DEPTH_EXT);
        rd_valid  = !buf_empty;
        pop       = rd_valid && rd_ready;
        occupancy = buf_count + {1'b0, inflight_q};
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        inflight_d   = 1'b0;
        err_d        = err_q;
        issue        = 1'b0;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        mem_wr       = 1'b0;
        mem_data     = '0;
        mem_address  = addr_q;
        done         = 1'b0;
        err          = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    issue_left_d = cmd_len;
                    out_left_d   = cmd_len;
                    err_d        = addr_bad;
                    // Keep the RAM address inside the array for rejected commands.
                    if (!addr_bad) begin
                        addr_d = cmd_addr;
                    end
                    if (addr_bad || (cmd_len == '0)) begin
                        state_d = DONE;
                    end else if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            WRITE: begin
                wr_ready = 1'b1;
                mem_wr   = wr_valid;
                mem_data = wr_data;
                if (wr_valid) begin
                    addr_d       = addr_next;
                    issue_left_d = issue_left_q - LW'(1);
                    if (issue_left_q == LW'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            READ: begin
                // A pop this cycle frees a slot for the word issued now, which
                // keeps the stream gap-free while never holding more than two.
                issue = (issue_left_q != '0) && ((occupancy < 2'd2) || pop);
                if (issue) begin
                    addr_d       = addr_next;
                    issue_left_d = issue_left_q - LW'(1);
                    inflight_d   = 1'b1;
                end
                if (pop) begin
                    out_left_d = out_left_q - LW'(1);
                    if (out_left_q == LW'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            inflight_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            inflight_q   <= inflight_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_burst_ctrl
// Bench for bram_burst_ctrl with a behavioural single-port RAM attached.
// Expected RAM contents are tracked in ref_mem from the burst rules
// (start address plus offset, wrapping at the RAM depth).
// ---------------------------------------------------------------------------
module tb_bram_burst_ctrl;

    localparam int DEPTH = 4092;
    localparam int DW    = 16;
    localparam int MAXB  = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          done;
    logic          err;
    logic          mem_wr;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_burst_ctrl #(
        .ADDRESS_DEPTH (DEPTH),
        .DATA_WIDTH    (DW),
        .MAX_BURST     (MAXB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .done        (done),
        .err         (err),
        .mem_wr      (mem_wr),
        .mem_data    (mem_data),
        .mem_address (mem_address),
        .mem_q       (mem_q)
    );

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        if (mem_wr && (int'(mem_address) < DEPTH)) ram[mem_address] <= mem_data;
        mem_q <= (int'(mem_address) < DEPTH) ? ram[mem_address] : '0;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        checks++; if (mem_address !== '0) begin errors++; $display("FAIL reset_mem_address: got %0d expected 0", mem_address); end
        checks++; if (mem_data !== '0) begin errors++; $display("FAIL reset_mem_data: got %0h expected 0", mem_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // base >= 0 gives data base, base+1, ...; otherwise random data.
    task automatic do_write(input int addr, input int len, input int base, input bit gaps,
                            input bit noise);
        int            idx = 0;
        int            cyc = 0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(addr); cmd_len = LW'(len);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready: got %b expected 1", cmd_ready); end
        while (idx < len && cyc < 4 * len + 20) begin
            @(negedge clk);
            cmd_valid = noise;
            if (noise) begin
                cmd_write = 1'($urandom);
                cmd_addr  = AW'($urandom_range(0, DEPTH - 1));
                cmd_len   = LW'($urandom_range(1, 20));
            end
            wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d        = (base >= 0) ? DW'(base + idx) : DW'($urandom);
            wr_data  = d;
            #1;
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", wr_ready); end
            checks++; if (mem_wr !== wr_valid) begin errors++; $display("FAIL wr_mem_wr: got %b expected %b", mem_wr, wr_valid); end
            if (noise) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready: got %b expected 0", cmd_ready); end
            end
            if (wr_valid) begin
                a = AW'((addr + idx) % DEPTH);
                checks++; if (mem_address !== a) begin errors++; $display("FAIL wr_address: got %0d expected %0d", mem_address, a); end
                checks++; if (mem_data !== d) begin errors++; $display("FAIL wr_mem_data: got %0h expected %0h", mem_data, d); end
                ref_mem[a] = d;
                idx++;
            end
            cyc++;
        end
        checks++; if (idx != len) begin errors++; $display("FAIL wr_timeout: got %0d words expected %0d", idx, len); end
        @(negedge clk);
        wr_valid = 1'b0; cmd_valid = 1'b0;
        #1;
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wr_done: got done=%b err=%b expected 1 0", done, err); end
        checks++; if (mem_wr !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_done_state: got mem_wr=%b cmd_ready=%b expected 0 0", mem_wr, cmd_ready); end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_after_done: got done=%b cmd_ready=%b expected 0 1", done, cmd_ready); end
    endtask

    // Reads len words from addr; rand_ready toggles rd_ready randomly.
    task automatic do_read(input int addr, input int len, input bit rand_ready);
        int            idx = 0;
        int            cyc = 0;
        bit            first = 1'b1;
        logic [DW-1:0] exp;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(addr); cmd_len = LW'(len);
        rd_ready  = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_cmd_ready: got %b expected 1", cmd_ready); end
        // Edge E accepts the command; the first word must appear after E+2.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b expected 0 at cycle %0d", rd_valid, k); end
        end
        while (idx < len && cyc < 6 * len + 20) begin
            @(negedge clk);
            rd_ready = rand_ready ? 1'($urandom) : 1'b1;
            #1;
            if (first) begin
                checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_first_valid: got %b expected 1", rd_valid); end
                first = 1'b0;
            end else if (!rand_ready) begin
                checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_bubble: got %b expected 1 at word %0d", rd_valid, idx); end
            end
            checks++; if (mem_wr !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rd_busy: got mem_wr=%b done=%b expected 0 0", mem_wr, done); end
            if (rd_valid) begin
                exp = ref_mem[(addr + idx) % DEPTH];
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL rd_data: got %0h expected %0h at word %0d", rd_data, exp, idx); end
                if (rd_ready) idx++;
            end
            cyc++;
        end
        checks++; if (idx != len) begin errors++; $display("FAIL rd_timeout: got %0d words expected %0d", idx, len); end
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rd_done: got done=%b err=%b expected 1 0", done, err); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_extra_word: got rd_valid=%b expected 0", rd_valid); end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_after_done: got done=%b cmd_ready=%b expected 0 1", done, cmd_ready); end
    endtask

    task automatic do_illegal(input int addr, input int len, input logic exp_err);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = AW'(addr); cmd_len = LW'(len);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ill_cmd_ready: got %b expected 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checks++; if (done !== 1'b1 || err !== exp_err) begin errors++; $display("FAIL ill_done: got done=%b err=%b expected 1 %b", done, err, exp_err); end
        checks++; if (mem_wr !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL ill_access: got mem_wr=%b wr_ready=%b rd_valid=%b expected 0 0 0", mem_wr, wr_ready, rd_valid); end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL ill_after: got done=%b err=%b cmd_ready=%b expected 0 0 1", done, err, cmd_ready); end
    endtask

    task automatic test_basic();
        do_write(10, 4, 'hA0, 1'b0, 1'b0);
        do_read(10, 4, 1'b0);
    endtask

    task automatic test_wrap();
        do_write(4090, 4, 'h5A0, 1'b0, 1'b0);
        checks++; if (ref_mem[0] !== 16'h05A2 || ref_mem[1] !== 16'h05A3) begin errors++; $display("FAIL wrap_model: got %0h %0h expected 5a2 5a3", ref_mem[0], ref_mem[1]); end
        do_read(4090, 4, 1'b0);
    endtask

    task automatic test_backpressure();
        do_write(300, 8, -1, 1'b0, 1'b0);
        do_read(300, 8, 1'b1);
    endtask

    task automatic test_write_gaps();
        do_write(700, 3, 'h3C0, 1'b1, 1'b0);
        do_read(700, 3, 1'b0);
    endtask

    task automatic test_illegal();
        do_illegal(50, 0, 1'b0);
        do_illegal(4095, 5, 1'b1);
        do_illegal(4092, 0, 1'b1);
        // Commands offered during a burst must not disturb it.
        do_write(100, 5, 'h700, 1'b1, 1'b1);
        do_read(100, 5, 1'b1);
    endtask

    task automatic test_reset_mid_read();
        do_write(500, 16, -1, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(500); cmd_len = LW'(16);
        rd_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rst_mid: got rd_valid=%b cmd_ready=%b done=%b expected 0 1 0", rd_valid, cmd_ready, done); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++; if (done !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL rst_no_done: got done=%b rd_valid=%b expected 0 0", done, rd_valid); end
        end
        rd_ready = 1'b0;
        do_read(500, 16, 1'b0);
    endtask

    task automatic test_random();
        int addr;
        int len;
        for (int n = 0; n < 6; n++) begin
            addr = ($urandom_range(0, 1) != 0) ? DEPTH - 1 - $urandom_range(0, 9)
                                               : $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 20);
            do_write(addr, len, -1, 1'b1, 1'b0);
            do_read(addr, len, 1'b1);
        end
        do_write(1000, MAXB, -1, 1'b0, 1'b0);
        do_read(1000, MAXB, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_write_gaps();
        test_illegal();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
